adc_sample_filter: RTL

//  Consumes 16-bit ADC words from the SPI slave receiver and produces a boxcar-averaged

---
 rtl/adc_sample_filter.sv | 86 ++++++++
 1 files changed

// File: rtl/adc_sample_filter.sv
// adc_sample_filter: boxcar average of SPI ADC words with stale/overrun flags.
// Define ADC_HYSTERESIS_EN to suppress output updates smaller than HYST while running.
module adc_sample_filter #(
  parameter int          AVG_LOG2 = 2,
  parameter logic [15:0] TIMEOUT  = 16'hFFFF,
  parameter logic [15:0] HYST     = 16'd8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [0:15] sample_in,
  input  logic        sample_valid,
  output logic [15:0] filt_out,
  output logic        filt_valid,
  output logic        stale,
  output logic        overrun
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW = 16 + AVG_LOG2;
  localparam int PW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  typedef enum logic {PRIME, RUN} state_t;
  state_t state, state_nx;
  logic sv_q, v1, v2, p2, edge_e, busy, to_hit, upd;
  logic [15:0] w_q, avg_q, cnt;
  logic [15:0] buf_q [DEPTH];
  logic [SW-1:0] sum, sum_nx;
  logic [PW-1:0] ptr;
  always_comb begin
    edge_e = sample_valid & ~sv_q;
    busy = v1 | v2;
    to_hit = ~edge_e && cnt == TIMEOUT - 16'd1;
    sum_nx = sum + SW'(w_q) - SW'(buf_q[ptr]);
    state_nx = to_hit ? PRIME : (v1 ? RUN : state);
`ifdef ADC_HYSTERESIS_EN
    upd = p2 || ((avg_q > filt_out ? avg_q - filt_out : filt_out - avg_q) >= HYST);
`else
    upd = 1'b1;
`endif
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= PRIME;
    else state <= state_nx;
  // Stage 1 captures the word; [0:15] to [15:0] assignment keeps wire-first bit as MSB.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sv_q <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      p2 <= 1'b0;
      w_q <= '0;
      avg_q <= '0;
      cnt <= '0;
      sum <= '0;
      ptr <= '0;
      filt_out <= '0;
      filt_valid <= 1'b0;
      stale <= 1'b1;
      overrun <= 1'b0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      sv_q <= sample_valid;
      v1 <= edge_e & ~busy;
      v2 <= v1;
      overrun <= edge_e & busy;
      if (edge_e & ~busy) w_q <= sample_in;
      cnt <= edge_e ? 16'd0 : (cnt == TIMEOUT ? cnt : cnt + 16'd1);
      if (to_hit) stale <= 1'b1;
      if (v1) begin
        p2 <= state == PRIME;
        if (state == PRIME) begin
          for (int i = 0; i < DEPTH; i++) buf_q[i] <= w_q;
          sum <= SW'(w_q) << AVG_LOG2;
          ptr <= '0;
          avg_q <= w_q;
          stale <= 1'b0;
        end else begin
          buf_q[ptr] <= w_q;
          sum <= sum_nx;
          ptr <= ptr == PW'(DEPTH - 1) ? '0 : ptr + 1'b1;
          avg_q <= 16'(sum_nx >> AVG_LOG2);
        end
      end
      filt_valid <= v2 & upd;
      if (v2 & upd) filt_out <= avg_q;
    end
  end
endmodule
